// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the RISCAT multi-port register file.
//   DEF_XLEN / DEF_NREGS : default data width and architectural register count
//   DEF_AW               : default register-address width
//   reg_addr_t / xlen_t  : address and data types at the default sizes
//   REG_ZERO             : architectural index of the hard-wired zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register, tracking in-flight producers.
// A reservation sets the bit, a write clears it. A reservation wins over a
// same-cycle write to the same register, because the new producer is younger.
// With ZERO_REG=1, bit 0 never sets.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   rsv_en, rsv_addr    : reserve request from issue
//   wr_en, wr_addr      : writeback, releases the reservation
//   busy_vec            : registered busy bits, bit i = register i
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS    = DEF_NREGS,
  parameter  bit ZERO_REG = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Next busy state: set beats clear, otherwise hold; zero register masked
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < NREGS; r++) begin
      if (rsv_en && (rsv_addr == AW'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (wr_en && (wr_addr == AW'(r))) begin
        w_busy_nxt[r] = 1'b0;
      end else begin
        w_busy_nxt[r] = r_busy[r];
      end
    end
    if (ZERO_REG) begin
      w_busy_nxt[0] = 1'b0;
    end else begin
      w_busy_nxt[0] = w_busy_nxt[0];
    end
  end

  // Busy-bit state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

endmodule : regfile_scoreboard

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-port integer register file with an integrated busy-bit scoreboard.
// There are NRD combinational read ports and one synchronous write port. An
// optional same-cycle forward sends write data to the read ports.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   rd_en   [NRD]       : per-port read enable (disabled port reads 0, not busy)
//   rd_addr [NRD*AW]    : per-port read address, port i at [i*AW +: AW]
//   rd_data [NRD*XLEN]  : per-port read data,    port i at [i*XLEN +: XLEN]
//   rd_busy [NRD]       : addressed register has a pending producer
//   wr_en, wr_addr, wr_data : write port; a write also releases the reservation
//   rsv_en, rsv_addr    : reserve a destination register at issue
//   busy_vec [NREGS]    : current busy bits
// -----------------------------------------------------------------------------
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NRD      = 2,
  parameter  bit BYPASS   = 1'b1,
  parameter  bit ZERO_REG = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] w_mem [NREGS];

  // ---------------------------------------------------------------------------
  // Storage. With ZERO_REG the entry for register 0 is not built at all; it is
  // a constant zero, so writes to it vanish without any extra gating.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NREGS; g++) begin : g_mem
    if (ZERO_REG && (g == 0)) begin : g_zero
      assign w_mem[g] = '0;
    end else begin : g_reg
      logic [XLEN-1:0] r_val;

      // Capture write data when this entry is the write target
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_val <= '0;
        end else if (wr_en && (wr_addr == AW'(g))) begin
          r_val <= wr_data;
        end else begin
          r_val <= r_val;
        end
      end

      assign w_mem[g] = r_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  // ---------------------------------------------------------------------------
  // Read ports. Priority: disabled, then zero register, then forward, then
  // stored value. A forwarded read reports not-busy because the producer
  // completes in this very cycle.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = rd_addr[p*AW +: AW];

    // Read mux with zero-register and write-forward priority
    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (!rd_en[p]) begin
        w_data = '0;
        w_busy = 1'b0;
      end else if (ZERO_REG && (w_addr == AW'(REG_ZERO))) begin
        w_data = '0;
        w_busy = 1'b0;
      end else if (BYPASS && wr_en && (wr_addr == w_addr)) begin
        w_data = wr_data;
        w_busy = 1'b0;
      end else begin
        w_data = w_mem[w_addr];
        w_busy = busy_vec[w_addr];
      end
    end

    assign rd_data[p*XLEN +: XLEN] = w_data;
    assign rd_busy[p]              = w_busy;
  end

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Stimulus shared by DUT A (BYPASS=1) and DUT B (BYPASS=0)
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_busy, b_rd_busy;
  logic [31:0] a_busy_vec, b_busy_vec;

  // DUT C: NREGS=16, NRD=4, XLEN=64
  logic [3:0]   c_rd_en;
  logic [15:0]  c_rd_addr;
  logic [255:0] c_rd_data;
  logic [3:0]   c_rd_busy;
  logic         c_wr_en;
  logic [3:0]   c_wr_addr;
  logic [63:0]  c_wr_data;
  logic         c_rsv_en;
  logic [3:0]   c_rsv_addr;
  logic [15:0]  c_busy_vec;

  register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_a (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(a_busy_vec));

  register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(b_busy_vec));

  register_file_mp #(.XLEN(64), .NREGS(16), .NRD(4), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_c (
    .clk(clk), .reset(reset), .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr), .busy_vec(c_busy_vec));

  // Reference model: plain arrays of architectural state
  logic [31:0] mem_m   [32];
  bit          busy_m  [32];
  logic [63:0] memc_m  [16];
  bit          busyc_m [16];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] ref_rd(input int p, input bit byp);
    int a;
    a = int'(rd_addr[p*5 +: 5]);
    if (!rd_en[p]) return 32'h0;
    if (a == 0) return 32'h0;
    if (byp && wr_en && (int'(wr_addr) == a)) return wr_data;
    return mem_m[a];
  endfunction

  function automatic bit ref_bz(input int p, input bit byp);
    int a;
    a = int'(rd_addr[p*5 +: 5]);
    if (!rd_en[p]) return 1'b0;
    if (a == 0) return 1'b0;
    if (byp && wr_en && (int'(wr_addr) == a)) return 1'b0;
    return busy_m[a];
  endfunction

  function automatic logic [31:0] ref_bv();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  function automatic logic [63:0] ref_rd_c(input int p);
    int a;
    a = int'(c_rd_addr[p*4 +: 4]);
    if (!c_rd_en[p]) return 64'h0;
    if (a == 0) return 64'h0;
    if (c_wr_en && (int'(c_wr_addr) == a)) return c_wr_data;
    return memc_m[a];
  endfunction

  function automatic bit ref_bz_c(input int p);
    int a;
    a = int'(c_rd_addr[p*4 +: 4]);
    if (!c_rd_en[p]) return 1'b0;
    if (a == 0) return 1'b0;
    if (c_wr_en && (int'(c_wr_addr) == a)) return 1'b0;
    return busyc_m[a];
  endfunction

  function automatic logic [15:0] ref_bv_c();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = busyc_m[i];
    return v;
  endfunction

  task automatic idle();
    rd_en = 2'b00; rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    rsv_en = 1'b0; rsv_addr = 5'd0;
    c_rd_en = 4'd0; c_rd_addr = 16'd0; c_wr_en = 1'b0; c_wr_addr = 4'd0; c_wr_data = 64'd0;
    c_rsv_en = 1'b0; c_rsv_addr = 4'd0;
  endtask

  // Advance one rising edge and apply the architectural rules to the model
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin mem_m[i] = 32'd0; busy_m[i] = 1'b0; end
      for (int i = 0; i < 16; i++) begin memc_m[i] = 64'd0; busyc_m[i] = 1'b0; end
    end else begin
      if (wr_en && (wr_addr != 5'd0)) begin mem_m[wr_addr] = wr_data; busy_m[wr_addr] = 1'b0; end
      if (rsv_en && (rsv_addr != 5'd0)) busy_m[rsv_addr] = 1'b1;
      if (c_wr_en && (c_wr_addr != 4'd0)) begin memc_m[c_wr_addr] = c_wr_data; busyc_m[c_wr_addr] = 1'b0; end
      if (c_rsv_en && (c_rsv_addr != 4'd0)) busyc_m[c_rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111_2222; rsv_en = 1'b1; rsv_addr = 5'd6;
    c_rsv_en = 1'b1; c_rsv_addr = 4'd6;
    step();
    // Write/reserve pending when reset hits mid-cycle: must be lost
    wr_addr = 5'd12; wr_data = 32'h3333_4444; rsv_addr = 5'd13; c_rsv_addr = 4'd13;
    rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    #1; reset = 1'b1; #1;
    checks += 3;
    if (a_busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy_a: got %h want 0", a_busy_vec); end
    if (b_busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy_b: got %h want 0", b_busy_vec); end
    if (c_busy_vec !== 16'd0) begin errors++; $display("FAIL reset_busy_c: got %h want 0", c_busy_vec); end
    checks += 4;
    if (a_rd_data !== 64'd0) begin errors++; $display("FAIL reset_x5_data_a: got %h want 0", a_rd_data); end
    if (b_rd_data !== 64'd0) begin errors++; $display("FAIL reset_x5_data_b: got %h want 0", b_rd_data); end
    if (a_rd_busy !== 2'b00) begin errors++; $display("FAIL reset_x5_busy_a: got %b want 00", a_rd_busy); end
    if (b_rd_busy !== 2'b00) begin errors++; $display("FAIL reset_x5_busy_b: got %b want 00", b_rd_busy); end
    step();
    idle();
    reset = 1'b0;
    step();
    rd_en = 2'b11; rd_addr = {5'd13, 5'd12};
    #2;
    checks += 3;
    if (a_rd_data !== 64'd0) begin errors++; $display("FAIL reset_lost_write: got %h want 0", a_rd_data); end
    if (a_rd_busy !== 2'b00) begin errors++; $display("FAIL reset_lost_rsv: got %b want 00", a_rd_busy); end
    if (a_busy_vec !== 32'd0) begin errors++; $display("FAIL reset_after_busy: got %h want 0", a_busy_vec); end
    step();
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    step();
    wr_addr = 5'd0; wr_data = 32'h0000_1234;
    step();
    idle();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd7};
    #2;
    checks += 3;
    if (a_rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_x7: got %h want deadbeef", a_rd_data[31:0]); end
    if (b_rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_x7_b: got %h want deadbeef", b_rd_data[31:0]); end
    if (a_rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL wr_rd_x0: got %h want 0", a_rd_data[63:32]); end
    step();
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    #2;
    checks += 4;
    if (a_rd_data[63:32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_data: got %h want a5a5a5a5", a_rd_data[63:32]); end
    if (a_rd_busy[1] !== 1'b0) begin errors++; $display("FAIL bypass_busy: got %b want 0", a_rd_busy[1]); end
    if (b_rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL nobypass_old: got %h want 0", b_rd_data[63:32]); end
    if (a_rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL bypass_port0_off: got %h want 0", a_rd_data[31:0]); end
    step();
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    #2;
    checks += 3;
    if (a_busy_vec[9] !== 1'b1) begin errors++; $display("FAIL rsv_busy_vec: got %b want 1", a_busy_vec[9]); end
    if (a_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rsv_rd_busy: got %b want 1", a_rd_busy[0]); end
    if (b_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rsv_rd_busy_b: got %b want 1", b_rd_busy[0]); end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h42;
    #1;
    checks += 3;
    if (a_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL fwd_clears_busy: got %b want 0", a_rd_busy[0]); end
    if (b_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL nobypass_prebusy: got %b want 1", b_rd_busy[0]); end
    if (b_rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL nobypass_prewrite: got %h want 0", b_rd_data[31:0]); end
    step();
    wr_en = 1'b0;
    #2;
    checks += 3;
    if (a_busy_vec[9] !== 1'b0) begin errors++; $display("FAIL wr_clears_busy: got %b want 0", a_busy_vec[9]); end
    if (a_rd_data[31:0] !== 32'h42) begin errors++; $display("FAIL wr_x9_data: got %h want 42", a_rd_data[31:0]); end
    if (b_rd_data[31:0] !== 32'h42) begin errors++; $display("FAIL wr_x9_data_b: got %h want 42", b_rd_data[31:0]); end
    step();
  endtask

  task automatic test_simultaneous();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    step();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
    #2;
    checks += 3;
    if (a_rd_data[31:0] !== 32'h55) begin errors++; $display("FAIL simul_data: got %h want 55", a_rd_data[31:0]); end
    if (a_busy_vec[4] !== 1'b1) begin errors++; $display("FAIL simul_busy: got %b want 1", a_busy_vec[4]); end
    if (a_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL simul_rd_busy: got %b want 1", a_rd_busy[0]); end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    idle();
    #2;
    checks += 2;
    if (a_busy_vec[0] !== 1'b0) begin errors++; $display("FAIL rsv_x0: got %b want 0", a_busy_vec[0]); end
    if (a_busy_vec !== ref_bv()) begin errors++; $display("FAIL simul_vec: got %h want %h", a_busy_vec, ref_bv()); end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 250; n++) begin
      rd_en    = 2'($urandom);
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_en    = 1'($urandom);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      if ((n % 23) == 0) rd_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      #2;
      for (int p = 0; p < 2; p++) begin
        checks += 4;
        if (a_rd_data[p*32 +: 32] !== ref_rd(p, 1'b1)) begin errors++;
          $display("FAIL rand_data_a p%0d n%0d: got %h want %h", p, n, a_rd_data[p*32 +: 32], ref_rd(p, 1'b1)); end
        if (a_rd_busy[p] !== ref_bz(p, 1'b1)) begin errors++;
          $display("FAIL rand_busy_a p%0d n%0d: got %b want %b", p, n, a_rd_busy[p], ref_bz(p, 1'b1)); end
        if (b_rd_data[p*32 +: 32] !== ref_rd(p, 1'b0)) begin errors++;
          $display("FAIL rand_data_b p%0d n%0d: got %h want %h", p, n, b_rd_data[p*32 +: 32], ref_rd(p, 1'b0)); end
        if (b_rd_busy[p] !== ref_bz(p, 1'b0)) begin errors++;
          $display("FAIL rand_busy_b p%0d n%0d: got %b want %b", p, n, b_rd_busy[p], ref_bz(p, 1'b0)); end
      end
      checks += 2;
      if (a_busy_vec !== ref_bv()) begin errors++; $display("FAIL rand_vec_a n%0d: got %h want %h", n, a_busy_vec, ref_bv()); end
      if (b_busy_vec !== ref_bv()) begin errors++; $display("FAIL rand_vec_b n%0d: got %h want %h", n, b_busy_vec, ref_bv()); end
      step();
    end
    idle();
  endtask

  task automatic test_sweep();
    logic [63:0] vals [4];
    idle();
    for (int i = 0; i < 4; i++) begin
      vals[i]   = {32'($urandom), 28'hC0FFEE0, 4'(i)};
      c_wr_en   = 1'b1;
      c_wr_addr = 4'(i + 1);
      c_wr_data = vals[i];
      step();
    end
    idle();
    c_rd_en = 4'hF; c_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    #2;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (c_rd_data[p*64 +: 64] !== vals[p]) begin errors++;
        $display("FAIL sweep_port%0d: got %h want %h", p, c_rd_data[p*64 +: 64], vals[p]); end
    end
    c_rd_en = 4'b1011;
    #1;
    checks += 2;
    if (c_rd_data[128 +: 64] !== 64'd0) begin errors++; $display("FAIL sweep_port2_off: got %h want 0", c_rd_data[128 +: 64]); end
    if (c_rd_data[192 +: 64] !== vals[3]) begin errors++; $display("FAIL sweep_port3_on: got %h want %h", c_rd_data[192 +: 64], vals[3]); end
    step();
    for (int n = 0; n < 200; n++) begin
      c_rd_en    = 4'($urandom);
      c_rd_addr  = 16'($urandom);
      c_wr_en    = 1'($urandom);
      c_wr_addr  = 4'($urandom);
      c_wr_data  = {$urandom, $urandom};
      c_rsv_en   = ($urandom_range(0, 2) == 0);
      c_rsv_addr = 4'($urandom);
      #2;
      for (int p = 0; p < 4; p++) begin
        checks += 2;
        if (c_rd_data[p*64 +: 64] !== ref_rd_c(p)) begin errors++;
          $display("FAIL rand_data_c p%0d n%0d: got %h want %h", p, n, c_rd_data[p*64 +: 64], ref_rd_c(p)); end
        if (c_rd_busy[p] !== ref_bz_c(p)) begin errors++;
          $display("FAIL rand_busy_c p%0d n%0d: got %b want %b", p, n, c_rd_busy[p], ref_bz_c(p)); end
      end
      checks++;
      if (c_busy_vec !== ref_bv_c()) begin errors++; $display("FAIL rand_vec_c n%0d: got %h want %h", n, c_busy_vec, ref_bv_c()); end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_register_file_mp
